// File: rtl/mmio_io_ctrl_pkg.sv
// Shared constants and helpers for the MMIO I/O controller:
// default register map, 7-segment decode, KCTRL bit layout.
package mmio_pkg;

  localparam logic [31:0] ADDR_HEX_DEF   = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR_DEF  = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG_DEF  = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY_DEF   = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW_DEF    = 32'hF000_0014;
  localparam logic [31:0] ADDR_KCTRL_DEF = 32'hF000_0018;

  // active-low segments, bit order gfedcba
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic int kctrl_ovr_idx(input int nkey);
    return nkey;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// CPU-side data-memory port bundle for the MMIO controller.
// master = CPU, slave = controller.
interface mmio_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic             sel;
  logic [DBITS-1:0] rdata;
  logic             rvalid;

  modport master (
    output addr, wdata, we, re,
    input  sel, rdata, rvalid
  );

  modport slave (
    input  addr, wdata, we, re,
    output sel, rdata, rvalid
  );
endinterface

// File: rtl/mmio_io_ctrl_debounce.sv
// 2-flop synchroniser followed by per-bit consecutive-cycle debounce.
// Output changes only after DEBN_CYCLES stable differing samples.
module io_debounce #(
  parameter int              WIDTH       = 1,
  parameter int              DEBN_CYCLES = 16,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = (DEBN_CYCLES > 1) ? $clog2(DEBN_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBN_CYCLES - 1);

  logic [WIDTH-1:0]         s1_q, s1_d;
  logic [WIDTH-1:0]         s2_q, s2_d;
  logic [WIDTH-1:0]         stb_q, stb_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d  = din;
    s2_d  = s1_q;
    stb_d = stb_q;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] != stb_q[i]) begin
        if (cnt_q[i] == CMAX) stb_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      stb_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      stb_q <= stb_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = stb_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller for LEDs, 7-seg digits, switches and keys.
// HEX_DECODE_EN: HEX register holds nibbles decoded to segments.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int DBITS       = 32,
  parameter int NHEX        = 4,
  parameter int NLEDR       = 10,
  parameter int NLEDG       = 8,
  parameter int NKEY        = 4,
  parameter int NSW         = 10,
  parameter int DEBN_CYCLES = 16,
  parameter logic [DBITS-1:0] ADDR_HEX   = DBITS'(ADDR_HEX_DEF),
  parameter logic [DBITS-1:0] ADDR_LEDR  = DBITS'(ADDR_LEDR_DEF),
  parameter logic [DBITS-1:0] ADDR_LEDG  = DBITS'(ADDR_LEDG_DEF),
  parameter logic [DBITS-1:0] ADDR_KEY   = DBITS'(ADDR_KEY_DEF),
  parameter logic [DBITS-1:0] ADDR_SW    = DBITS'(ADDR_SW_DEF),
  parameter logic [DBITS-1:0] ADDR_KCTRL = DBITS'(ADDR_KCTRL_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  mmio_if.slave             bus,
  input  logic [NSW-1:0]    SW,
  input  logic [NKEY-1:0]   KEY,
  output logic [NLEDR-1:0]  LEDR,
  output logic [NLEDG-1:0]  LEDG,
  output logic [7*NHEX-1:0] HEX
);

  localparam int KW  = NKEY + 1;
  localparam int OVR = kctrl_ovr_idx(NKEY);
`ifdef HEX_DECODE_EN
  localparam int HW = 4 * NHEX;
  localparam logic [HW-1:0] HEX_RST = '0;
`else
  localparam int HW = 7 * NHEX;
  localparam logic [HW-1:0] HEX_RST = '1;
`endif

  logic [NSW-1:0]   sw_db;
  logic [NKEY-1:0]  key_db, prs, rise;
  logic [NKEY-1:0]  prs_q, prs_d;
  logic [NLEDR-1:0] ledr_q, ledr_d;
  logic [NLEDG-1:0] ledg_q, ledg_d;
  logic [HW-1:0]    hex_q, hex_d;
  logic [KW-1:0]    kc_q, kc_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             hit_hex, hit_ledr, hit_ledg;
  logic             hit_key, hit_sw, hit_kc, wr;
  logic             unused_wdata;

  io_debounce #(
    .WIDTH(NSW), .DEBN_CYCLES(DEBN_CYCLES),
    .RST_VAL('0)
  ) u_sw_db (
    .clk(clk), .reset(reset), .din(SW), .dout(sw_db)
  );

  // keys idle high, so the raw path resets to all-ones
  io_debounce #(
    .WIDTH(NKEY), .DEBN_CYCLES(DEBN_CYCLES),
    .RST_VAL({NKEY{1'b1}})
  ) u_key_db (
    .clk(clk), .reset(reset), .din(KEY), .dout(key_db)
  );

  assign hit_hex  = bus.addr == ADDR_HEX;
  assign hit_ledr = bus.addr == ADDR_LEDR;
  assign hit_ledg = bus.addr == ADDR_LEDG;
  assign hit_key  = bus.addr == ADDR_KEY;
  assign hit_sw   = bus.addr == ADDR_SW;
  assign hit_kc   = bus.addr == ADDR_KCTRL;
  assign bus.sel  = hit_hex | hit_ledr | hit_ledg |
                    hit_key | hit_sw | hit_kc;
  assign wr       = bus.we & bus.sel;
  assign prs      = ~key_db;
  assign rise     = prs & ~prs_q;
  assign unused_wdata = ^bus.wdata;

  always_comb begin
    ledr_d   = ledr_q;
    ledg_d   = ledg_q;
    hex_d    = hex_q;
    kc_d     = kc_q;
    prs_d    = prs;
    rdata_d  = rdata_q;
    rvalid_d = bus.re;
    if (wr) begin
      unique case (1'b1)
        hit_ledr: ledr_d = bus.wdata[NLEDR-1:0];
        hit_ledg: ledg_d = bus.wdata[NLEDG-1:0];
        hit_hex:  hex_d  = bus.wdata[HW-1:0];
        hit_kc:   kc_d   = kc_q & ~bus.wdata[KW-1:0];
        default:  ;
      endcase
    end
    // new events are applied after W1C so a same-cycle set wins
    kc_d[NKEY-1:0] = kc_d[NKEY-1:0] | rise;
    if (|(rise & kc_q[NKEY-1:0])) kc_d[OVR] = 1'b1;
    if (bus.re) begin
      unique case (1'b1)
        hit_hex:  rdata_d = DBITS'(hex_q);
        hit_ledr: rdata_d = DBITS'(ledr_q);
        hit_ledg: rdata_d = DBITS'(ledg_q);
        hit_key:  rdata_d = DBITS'(prs);
        hit_sw:   rdata_d = DBITS'(sw_db);
        hit_kc:   rdata_d = DBITS'(kc_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ledr_q   <= '0;
      ledg_q   <= '0;
      hex_q    <= HEX_RST;
      kc_q     <= '0;
      prs_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      hex_q    <= hex_d;
      kc_q     <= kc_d;
      prs_q    <= prs_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign LEDR       = ledr_q;
  assign LEDG       = ledg_q;

`ifdef HEX_DECODE_EN
  always_comb begin
    HEX = '1;
    for (int i = 0; i < NHEX; i++)
      HEX[7*i +: 7] = seg7(hex_q[4*i +: 4]);
  end
`else
  assign HEX = hex_q;
`endif

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Scoreboarded random + directed bench for mmio_io_ctrl.
// Reference model tracks registers and a sample-window debounce.
module tb_mmio_io_ctrl;

  localparam int DBITS = 32;
  localparam int NHEX  = 4;
  localparam int NLEDR = 10;
  localparam int NLEDG = 8;
  localparam int NKEY  = 4;
  localparam int NSW   = 10;
  localparam int DEBN  = 16;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;
  localparam logic [31:0] A_KC   = 32'hF000_0018;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSW-1:0]    SW;
  logic [NKEY-1:0]   KEY;
  logic [NLEDR-1:0]  LEDR;
  logic [NLEDG-1:0]  LEDG;
  logic [7*NHEX-1:0] HEX;

  mmio_if #(.DBITS(DBITS)) bus ();

  mmio_io_ctrl #(
    .DBITS(DBITS), .NHEX(NHEX), .NLEDR(NLEDR), .NLEDG(NLEDG),
    .NKEY(NKEY), .NSW(NSW), .DEBN_CYCLES(DEBN)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .SW(SW), .KEY(KEY),
    .LEDR(LEDR), .LEDG(LEDG), .HEX(HEX)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  logic [31:0] exp_q[$];

  logic [NLEDR-1:0] m_ledr;
  logic [NLEDG-1:0] m_ledg;
  logic [31:0]      m_hex;
  logic [NKEY:0]    m_kc;
  logic [NSW-1:0]   m_sw;
  logic [NKEY-1:0]  m_prs, m_prs_prev;
  logic             m_rvalid;
  logic [NSW-1:0]   sw_pipe[$], sw_win[$];
  logic [NKEY-1:0]  pk_pipe[$], pk_win[$];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;
      4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;
      4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;
      4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;
      4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [31:0] exp_hex();
    logic [31:0] r;
    r = '0;
`ifdef HEX_DECODE_EN
    for (int i = 0; i < NHEX; i++)
      r[7*i +: 7] = seg_ref(m_hex[4*i +: 4]);
`else
    r = m_hex;
`endif
    return r;
  endfunction

  function automatic logic is_reg(input logic [31:0] a);
    return a == A_HEX || a == A_LEDR || a == A_LEDG ||
           a == A_KEY || a == A_SW || a == A_KC;
  endfunction

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    case (a)
      A_HEX:   return m_hex;
      A_LEDR:  return 32'(m_ledr);
      A_LEDG:  return 32'(m_ledg);
      A_KEY:   return 32'(m_prs);
      A_SW:    return 32'(m_sw);
      A_KC:    return 32'(m_kc);
      default: return 32'h0;
    endcase
  endfunction

  task automatic mdl_reset();
    m_ledr = '0;
    m_ledg = '0;
`ifdef HEX_DECODE_EN
    m_hex = 32'h0;
`else
    m_hex = 32'h0FFF_FFFF;
`endif
    m_kc = '0;
    m_sw = '0;
    m_prs = '0;
    m_prs_prev = '0;
    sw_pipe = '{'0, '0};
    pk_pipe = '{'0, '0};
    sw_win.delete();
    pk_win.delete();
  endtask

  // state after one clock edge, given inputs held across it
  task automatic mdl_edge(input logic [31:0] a, input logic [31:0] wd,
                          input logic w);
    logic [NKEY-1:0] rise;
    logic [NKEY:0]   kc_old;
    logic [NSW-1:0]  sw_s;
    logic [NKEY-1:0] pk_s;
    logic            flip;
    rise = m_prs & ~m_prs_prev;
    kc_old = m_kc;
    if (w) begin
      case (a)
`ifdef HEX_DECODE_EN
        A_HEX:  m_hex = {16'h0, wd[15:0]};
`else
        A_HEX:  m_hex = {4'h0, wd[27:0]};
`endif
        A_LEDR: m_ledr = wd[NLEDR-1:0];
        A_LEDG: m_ledg = wd[NLEDG-1:0];
        A_KC:   m_kc = m_kc & ~wd[NKEY:0];
        default: ;
      endcase
    end
    m_kc[NKEY-1:0] = m_kc[NKEY-1:0] | rise;
    if ((rise & kc_old[NKEY-1:0]) != '0) m_kc[NKEY] = 1'b1;
    sw_s = sw_pipe.pop_front();
    sw_pipe.push_back(SW);
    sw_win.push_back(sw_s);
    if (sw_win.size() > DEBN) void'(sw_win.pop_front());
    pk_s = pk_pipe.pop_front();
    pk_pipe.push_back(~KEY);
    pk_win.push_back(pk_s);
    if (pk_win.size() > DEBN) void'(pk_win.pop_front());
    m_prs_prev = m_prs;
    if (sw_win.size() == DEBN)
      for (int b = 0; b < NSW; b++) begin
        flip = 1'b1;
        foreach (sw_win[j]) if (sw_win[j][b] == m_sw[b]) flip = 1'b0;
        if (flip) m_sw[b] = ~m_sw[b];
      end
    if (pk_win.size() == DEBN)
      for (int b = 0; b < NKEY; b++) begin
        flip = 1'b1;
        foreach (pk_win[j]) if (pk_win[j][b] == m_prs[b]) flip = 1'b0;
        if (flip) m_prs[b] = ~m_prs[b];
      end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd,
                      input logic w, input logic r,
                      input logic rst = 1'b0, input logic pv = 1'b0,
                      input logic [31:0] pexp = 32'h0);
    bus.addr = a;
    bus.wdata = wd;
    bus.we = w;
    bus.re = r;
    reset = rst;
    @(negedge clk);
    #1;
    if (rst) mdl_reset();
    else begin
      if (r) exp_q.push_back(pv ? pexp : rd_val(a));
      mdl_edge(a, wd, w);
    end
    m_rvalid = r & ~rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 6))
      0: return A_HEX;
      1: return A_LEDR;
      2: return A_LEDG;
      3: return A_KEY;
      4: return A_SW;
      5: return A_KC;
      default: return 32'hF000_0020 + 32'($urandom_range(0, 15) * 4);
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("sel", 32'(bus.sel), 32'(is_reg(bus.addr)));
      chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
      if (bus.rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rdata_unexpected: got %h expected none",
                   bus.rdata);
        end else chk("rdata", bus.rdata, exp_q.pop_front());
      end
      chk("LEDR", 32'(LEDR), 32'(m_ledr));
      chk("LEDG", 32'(LEDG), 32'(m_ledg));
      chk("HEX", 32'(HEX), exp_hex());
    end
  end

  initial begin
    int sw_hold, key_hold;
    bit found;
    logic [31:0] a;
    bus.addr = '0;
    bus.wdata = '0;
    bus.we = 1'b0;
    bus.re = 1'b0;
    reset = 1'b1;
    SW = '0;
    KEY = '1;
    mdl_reset();
    m_rvalid = 1'b0;
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    started = 1'b1;
`ifdef HEX_DECODE_EN
    chk("rst_hex", 32'(HEX), 32'h0810_2040);
`else
    chk("rst_hex", 32'(HEX), 32'h0FFF_FFFF);
`endif
    chk("rst_ledr", 32'(LEDR), 32'h0);

    step(A_LEDR, 0, 0, 1, 0, 1, 32'h0);
    step(32'hF000_0020, 0, 0, 1, 0, 1, 32'h0);

    step(A_LEDR, 32'hFFFF_FFFF, 1, 0);
    step(A_LEDG, 32'h0000_00A5, 1, 0);
    chk("t2_ledr", 32'(LEDR), 32'h3FF);
    chk("t2_ledg", 32'(LEDG), 32'hA5);
    step(A_LEDR, 0, 0, 1, 0, 1, 32'h3FF);
    step(A_LEDG, 0, 0, 1, 0, 1, 32'hA5);
    // read-during-write returns the old value
    step(A_LEDG, 32'h3C, 1, 1, 0, 1, 32'hA5);

    SW = 10'h155;
    for (int t = 1; t <= 25; t++)
      step(A_SW, 0, 0, 1, 0, t == 18 || t == 19, t == 19 ? 32'h155 : 32'h0);
    SW = 10'h154;
    idle(5);
    SW = 10'h155;
    for (int t = 0; t < 25; t++) step(A_SW, 0, 0, 1, 0, 1, 32'h155);

    KEY = 4'b1101;
    idle(22);
    step(A_KC, 0, 0, 1, 0, 1, 32'h2);
    KEY = 4'b1111;
    idle(22);
    KEY = 4'b1101;
    idle(22);
    step(A_KC, 0, 0, 1, 0, 1, 32'h12);
    step(A_KC, 32'h12, 1, 0);
    step(A_KC, 0, 0, 1, 0, 1, 32'h0);

    KEY = 4'b1111;
    idle(22);
    KEY = 4'b1110;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (m_prs[0] && !m_prs_prev[0]) begin
        step(A_KC, 32'h1, 1, 0);
        found = 1'b1;
      end else idle(1);
    end
    chk("t5_rise_seen", 32'(found), 32'h1);
    step(A_KC, 0, 0, 1, 0, 1, 32'h1);

`ifdef HEX_DECODE_EN
    step(A_HEX, 32'h1234, 1, 0);
    chk("t6_dig0", 32'(HEX[6:0]), 32'h19);
    chk("t6_dig3", 32'(HEX[27:21]), 32'h79);
    step(A_HEX, 0, 0, 1, 0, 1, 32'h1234);
`else
    step(A_HEX, 32'h0, 1, 0);
    chk("t6_raw", 32'(HEX), 32'h0);
    step(A_HEX, 0, 0, 1, 0, 1, 32'h0);
`endif

    step(A_LEDR, 0, 0, 1, 1);
    idle(2);

    sw_hold = 0;
    key_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (sw_hold == 0) begin
        SW = NSW'($urandom);
        sw_hold = $urandom_range(1, 40);
      end
      if (key_hold == 0) begin
        KEY = NKEY'($urandom);
        key_hold = $urandom_range(1, 40);
      end
      sw_hold--;
      key_hold--;
      a = pick_addr();
      step(a, $urandom, $urandom_range(0, 9) < 3,
           $urandom_range(0, 1) == 1, $urandom_range(0, 499) == 0);
    end
    idle(3);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
